// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Two-port arbiter in front of a single asynchronous SRAM. Each requester
//   presents one read or write at a time through a valid/ready handshake.
//   Only one access is in flight: a write takes 2 cycles and a read takes
//   3 cycles. Read data comes back on the owning port with a one-cycle
//   rvalid pulse.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   rN_valid / rN_ready      request handshake, port N (N = 0, 1)
//   rN_we                    1 = write, 0 = read
//   rN_addr / rN_wdata       request address / write data
//   rN_rvalid / rN_rdata     read response pulse / held read data
//   busy                     high whenever an access is in progress
//   sram_cs/oe/we            active-low SRAM strobes
//   sram_addr                SRAM address
//   sram_data                bidirectional SRAM data bus, driven only while writing
module sram_arbiter #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r0_valid,
  output logic          r0_ready,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_valid,
  output logic          r1_ready,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_rdata,
  output logic          busy,
  output logic          sram_cs,
  output logic          sram_oe,
  output logic          sram_we,
  output logic [AW-1:0] sram_addr,
  inout  wire logic [DW-1:0] sram_data
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    RD_ADDR = 2'd2,
    RD_DATA = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic          last_q;
  logic          port_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata0_q, rdata1_q;
  logic          rvalid0_q, rvalid1_q;

  logic          gnt_port;
  logic          gnt_we;
  logic [AW-1:0] gnt_addr;
  logic [DW-1:0] gnt_wdata;
  logic          accept;

  // Arbitration: a lone request wins; on a tie the port not served last wins.
  always_comb begin
    gnt_port = 1'b0;
    if (r0_valid && r1_valid) begin
      gnt_port = ~last_q;
    end else if (r1_valid) begin
      gnt_port = 1'b1;
    end
    gnt_we    = gnt_port ? r1_we    : r0_we;
    gnt_addr  = gnt_port ? r1_addr  : r0_addr;
    gnt_wdata = gnt_port ? r1_wdata : r0_wdata;
  end

  // Readies are suppressed during reset so nothing is accepted on a reset edge.
  assign accept   = (state_q == IDLE) && !rst && (r0_valid || r1_valid);
  assign r0_ready = accept && !gnt_port;
  assign r1_ready = accept &&  gnt_port;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = gnt_we ? WRITE : RD_ADDR;
        end
      end
      WRITE:   state_d = IDLE;
      RD_ADDR: state_d = RD_DATA;
      RD_DATA: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // SRAM pins are a pure function of state and latched request fields.
  always_comb begin
    sram_cs   = 1'b1;
    sram_oe   = 1'b1;
    sram_we   = 1'b1;
    sram_addr = '0;
    busy      = 1'b1;
    unique case (state_q)
      IDLE: busy = 1'b0;
      WRITE: begin
        sram_cs   = 1'b0;
        sram_we   = 1'b0;
        sram_addr = addr_q;
      end
      RD_ADDR, RD_DATA: begin
        sram_cs   = 1'b0;
        sram_oe   = 1'b0;
        sram_addr = addr_q;
      end
      default: busy = 1'b0;
    endcase
  end

  assign sram_data = (state_q == WRITE) ? wdata_q : {DW{1'bz}};

  // Request latch, tie-break pointer and read-return registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q    <= 1'b1;
      port_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      if (accept) begin
        last_q  <= gnt_port;
        port_q  <= gnt_port;
        addr_q  <= gnt_addr;
        wdata_q <= gnt_wdata;
      end
      rvalid0_q <= (state_q == RD_DATA) && !port_q;
      rvalid1_q <= (state_q == RD_DATA) &&  port_q;
      if (state_q == RD_DATA) begin
        if (port_q) begin
          rdata1_q <= sram_data;
        end else begin
          rdata0_q <= sram_data;
        end
      end
    end
  end

  assign r0_rvalid = rvalid0_q;
  assign r1_rvalid = rvalid1_q;
  assign r0_rdata  = rdata0_q;
  assign r1_rdata  = rdata1_q;

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;
  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          r0_valid, r0_ready, r0_we, r0_rvalid;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata, r0_rdata;
  logic          r1_valid, r1_ready, r1_we, r1_rvalid;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata, r1_rdata;
  logic          busy, sram_cs, sram_oe, sram_we;
  logic [AW-1:0] sram_addr;
  wire  [DW-1:0] sram_data;

  logic [DW-1:0] mem [16];

  sram_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_we(r0_we), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .busy(busy), .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_data(sram_data)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM model
  assign sram_data = (!sram_cs && !sram_oe) ? mem[sram_addr] : {DW{1'bz}};
  always @(posedge clk) if (!sram_cs && !sram_we) mem[sram_addr] <= sram_data;

  typedef struct {
    bit         port;
    bit         we;
    logic [3:0] addr;
    logic [7:0] wdata;
    int         gap;   // expected cycles since previous accept, -1 = any
  } gnt_t;

  gnt_t       gq[$];
  logic [7:0] rq0[$], rq1[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard
  bit         mon_on = 1'b0;
  int         ph = 0;
  bit         ph_we;
  logic [3:0] ph_addr;
  logic [7:0] ph_wd;
  int         last_acc = -100;
  int         due0 = -1, due1 = -1;
  gnt_t       g;
  bit         p;

  always @(negedge clk) begin
    if (mon_on) begin
      chk("contention", int'(!sram_we && !sram_oe), 0);
      chk("ready_exclusive", int'(r0_ready && r1_ready), 0);
      chk("ready_while_busy", int'((r0_ready || r1_ready) && busy), 0);

      if (ph == 0) begin
        chk("idle_busy", busy, 0);
        chk("idle_cs", sram_cs, 1);
        chk("idle_we", sram_we, 1);
        chk("idle_oe", sram_oe, 1);
        chk("idle_addr", sram_addr, 0);
      end else if (ph_we) begin
        chk("wr_busy", busy, 1);
        chk("wr_cs", sram_cs, 0);
        chk("wr_we", sram_we, 0);
        chk("wr_oe", sram_oe, 1);
        chk("wr_addr", sram_addr, ph_addr);
        chk("wr_data", sram_data, ph_wd);
        ph = 0;
      end else begin
        chk("rd_busy", busy, 1);
        chk("rd_cs", sram_cs, 0);
        chk("rd_we", sram_we, 1);
        chk("rd_oe", sram_oe, 0);
        chk("rd_addr", sram_addr, ph_addr);
        ph = (ph == 1) ? 2 : 0;
      end

      if (r0_rvalid) begin
        if (rq0.size() == 0) chk("r0_spurious_rvalid", 1, 0);
        else begin
          chk("r0_rdata", r0_rdata, rq0.pop_front());
          chk("r0_latency", cyc, due0);
        end
      end
      if (r1_rvalid) begin
        if (rq1.size() == 0) chk("r1_spurious_rvalid", 1, 0);
        else begin
          chk("r1_rdata", r1_rdata, rq1.pop_front());
          chk("r1_latency", cyc, due1);
        end
      end

      if ((r0_valid && r0_ready) || (r1_valid && r1_ready)) begin
        p = r1_valid && r1_ready;
        if (gq.size() == 0) chk("unexpected_accept", 1, 0);
        else begin
          g = gq.pop_front();
          chk("grant_port", p, g.port);
          chk("grant_we", p ? r1_we : r0_we, g.we);
          chk("grant_addr", p ? r1_addr : r0_addr, g.addr);
          if (g.gap >= 0) chk("accept_gap", cyc - last_acc, g.gap);
          last_acc = cyc;
          ph = 1;
          ph_we = g.we;
          ph_addr = g.addr;
          ph_wd = g.wdata;
          if (!g.we) begin
            if (p) due1 = cyc + 3;
            else   due0 = cyc + 3;
          end
        end
      end
    end
  end

  task automatic req(input bit pt, input bit we, input logic [3:0] a, input logic [7:0] d);
    int n = 0;
    bit done = 1'b0;
    if (!pt) begin r0_we = we; r0_addr = a; r0_wdata = d; r0_valid = 1'b1; end
    else     begin r1_we = we; r1_addr = a; r1_wdata = d; r1_valid = 1'b1; end
    while (!done) begin
      @(negedge clk);
      done = pt ? r1_ready : r0_ready;
      n++;
      if (!done && n > 50) begin
        chk("req_timeout", 1, 0);
        done = 1'b1;
      end
    end
    @(posedge clk); #1;
    if (!pt) r0_valid = 1'b0; else r1_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((rq0.size() != 0 || rq1.size() != 0 || busy) && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) chk("drain_timeout", 1, 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    rst = 1'b1;
    r0_valid = 1'b1; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0;
    r1_valid = 1'b1; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0;

    // Reset state; readies held low while rst is high even with valids up
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_r0_ready", r0_ready, 0);
    chk("rst_r1_ready", r1_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_r0_rvalid", r0_rvalid, 0);
    chk("rst_r1_rvalid", r1_rvalid, 0);
    chk("rst_r0_rdata", r0_rdata, 0);
    chk("rst_r1_rdata", r1_rdata, 0);
    chk("rst_cs", sram_cs, 1);
    chk("rst_oe", sram_oe, 1);
    chk("rst_we", sram_we, 1);
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    mon_on = 1'b1;
    @(posedge clk); #1 rst = 1'b0;

    // Port 0 write then read of the same address
    gq.push_back('{1'b0, 1'b1, 4'd3, 8'hA5, -1});
    gq.push_back('{1'b0, 1'b0, 4'd3, 8'h00, 2});
    rq0.push_back(8'hA5);
    req(1'b0, 1'b1, 4'd3, 8'hA5);
    req(1'b0, 1'b0, 4'd3, 8'h00);
    drain();

    // Simultaneous writes after reset: port 0 wins the first tie
    do_reset();
    gq.push_back('{1'b0, 1'b1, 4'd1, 8'h11, -1});
    gq.push_back('{1'b1, 1'b1, 4'd2, 8'h22, 2});
    fork
      req(1'b0, 1'b1, 4'd1, 8'h11);
      req(1'b1, 1'b1, 4'd2, 8'h22);
    join
    drain();
    gq.push_back('{1'b0, 1'b0, 4'd1, 8'h00, -1});
    gq.push_back('{1'b1, 1'b0, 4'd2, 8'h00, 3});
    rq0.push_back(8'h11);
    rq1.push_back(8'h22);
    fork
      req(1'b0, 1'b0, 4'd1, 8'h00);
      req(1'b1, 1'b0, 4'd2, 8'h00);
    join
    drain();

    // Continuous reads from both ports alternate 0,1,0,1
    gq.push_back('{1'b0, 1'b0, 4'd3, 8'h00, -1});
    gq.push_back('{1'b1, 1'b0, 4'd2, 8'h00, 3});
    gq.push_back('{1'b0, 1'b0, 4'd1, 8'h00, 3});
    gq.push_back('{1'b1, 1'b0, 4'd1, 8'h00, 3});
    rq0.push_back(8'hA5); rq0.push_back(8'h11);
    rq1.push_back(8'h22); rq1.push_back(8'h11);
    fork
      begin req(1'b0, 1'b0, 4'd3, 8'h00); req(1'b0, 1'b0, 4'd1, 8'h00); end
      begin req(1'b1, 1'b0, 4'd2, 8'h00); req(1'b1, 1'b0, 4'd1, 8'h00); end
    join
    drain();
    chk("alt_r0_remaining", rq0.size(), 0);
    chk("alt_r1_remaining", rq1.size(), 0);

    // Reset during RD_DATA aborts the read without an rvalid
    gq.push_back('{1'b0, 1'b0, 4'd3, 8'h00, -1});
    req(1'b0, 1'b0, 4'd3, 8'h00);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_cs", sram_cs, 1);
    chk("abort_oe", sram_oe, 1);
    chk("abort_r0_rvalid", r0_rvalid, 0);
    chk("abort_r0_rdata", r0_rdata, 0);
    drain();

    // Port 1 read arrives while a port 0 write is in progress
    gq.push_back('{1'b0, 1'b1, 4'd5, 8'h5C, -1});
    gq.push_back('{1'b1, 1'b0, 4'd5, 8'h00, 2});
    rq1.push_back(8'h5C);
    fork
      req(1'b0, 1'b1, 4'd5, 8'h5C);
      begin
        @(posedge clk); #1;
        req(1'b1, 1'b0, 4'd5, 8'h00);
      end
    join
    drain();

    chk("grants_remaining", gq.size(), 0);
    chk("r0_reads_remaining", rq0.size(), 0);
    chk("r1_reads_remaining", rq1.size(), 0);
    mon_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
